// File: rtl/tanh_deriv_seq.sv
// -----------------------------------------------------------------------------
// tanh_deriv_seq
//   Backward-pass helper for the LSTM tanh unit. Computes
//     g     = 1 - y^2            (clamped to 0 when |y| >= 1.0)
//     delta = e * g
//   in signed Q(WIDTH-FRAC).FRAC fixed point, using a single iterative
//   shift-add multiplier that is reused for y*y and then |e|*g.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   i_start  request strobe, accepted only while o_ready=1
//   i_y      tanh activation y (signed)
//   i_err    backpropagated error e (signed)
//   o_ready  unit idle and able to accept i_start
//   o_valid  one-cycle pulse when o_dout/o_grad update
//   o_dout   delta = e*(1-y^2), held until the next result
//   o_grad   local gradient g = 1-y^2 (>= 0), held with o_dout
//
// Build option
//   TANH_DERIV_EARLY_EN : when defined, each multiply stops once the
//   remaining multiplier bits are zero, and a zero y or zero |e|*g operand
//   skips its multiply entirely. Results are unchanged; latency varies.
//   Without it, o_valid rises exactly 2*WIDTH+3 edges after acceptance.
// -----------------------------------------------------------------------------
module tanh_deriv_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_err,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_dout,
  output logic [WIDTH-1:0] o_grad
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0]   ONE    = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
  // 1.0 in the squared (2*FRAC fractional bits) scale of the accumulator.
  localparam logic [2*WIDTH-1:0] ONE_SQ = {{(2*WIDTH-1){1'b0}}, 1'b1} << (2*FRAC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ,
    S_SUB,
    S_MUL,
    S_DONE
  } state_t;

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   y_q,      y_d;
  logic [WIDTH-1:0]   e_q,      e_d;
  logic               e_neg_q,  e_neg_d;
  logic [WIDTH-1:0]   g_q,      g_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic               ready_q,  ready_d;
  logic               valid_q,  valid_d;
  logic [WIDTH-1:0]   dout_q,   dout_d;
  logic [WIDTH-1:0]   grad_q,   grad_d;

  // Shared shift-add step signals.
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   sq;
  logic [WIDTH-1:0]   prod;
  logic [WIDTH-1:0]   y_mag;
  logic [WIDTH-1:0]   e_mag;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
  // which is still correct when the result is read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign sq       = acc_q[FRAC+WIDTH-1:FRAC];
  assign prod     = acc_q[FRAC+WIDTH-1:FRAC];
  assign y_mag    = mag(y_q);
  assign e_mag    = mag(e_q);

  // NOTE: every signal written here takes a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    e_d      = e_q;
    e_neg_d  = e_neg_q;
    g_d      = g_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    valid_d  = 1'b0;
    dout_d   = dout_q;
    grad_d   = grad_q;

    case (state_q)
      S_IDLE: begin
        // o_ready is held low for the o_valid cycle and rises one cycle later.
        ready_d = 1'b1;
        if (i_start && ready_q) begin
          y_d     = i_y;
          e_d     = i_err;
          e_neg_d = i_err[WIDTH-1];
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = S_SQ;
        end
      end

      S_SQ: begin
        if (cnt_q == '0) begin
          // First SQ cycle forms |y| from the latched operand and loads it
          // as both multiplicand and multiplier.
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, y_mag};
          mplier_d = y_mag;
          cnt_d    = CW'(1);
`ifdef TANH_DERIV_EARLY_EN
          if (y_mag == '0) state_d = S_SUB;
`endif
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH)) state_d = S_SUB;
`ifdef TANH_DERIV_EARLY_EN
          if (mplier_q[WIDTH-1:1] == '0) state_d = S_SUB;
`endif
        end
      end

      S_SUB: begin
        // The clamp looks at the full square so that large |y| whose square
        // overflows the truncated window still clamps to zero.
        g_d      = (acc_q >= ONE_SQ) ? '0 : (ONE - sq);
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, e_mag};
        mplier_d = g_d;
        cnt_d    = '0;
        state_d  = S_MUL;
`ifdef TANH_DERIV_EARLY_EN
        if (g_d == '0 || e_mag == '0) state_d = S_DONE;
`endif
      end

      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
`ifdef TANH_DERIV_EARLY_EN
        if (mplier_q[WIDTH-1:1] == '0) state_d = S_DONE;
`endif
      end

      S_DONE: begin
        // Sign is applied after truncating the magnitude, so rounding is
        // toward zero and symmetric about 0.
        dout_d  = e_neg_q ? (~prod + WIDTH'(1)) : prod;
        grad_d  = g_q;
        valid_d = 1'b1;
        ready_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      y_q      <= '0;
      e_q      <= '0;
      e_neg_q  <= 1'b0;
      g_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      dout_q   <= '0;
      grad_q   <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      e_q      <= e_d;
      e_neg_q  <= e_neg_d;
      g_q      <= g_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
      grad_q   <= grad_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_dout  = dout_q;
  assign o_grad  = grad_q;

endmodule

// File: doc/tanh_deriv_seq.md
Name: tanh_deriv_seq

Overview:
Backward-pass companion to the forward tanh activation unit in the LSTM datapath. Takes a stored tanh activation y and an incoming error term e, and computes delta = e * (1 - y^2) in the team's signed Q12.20 fixed-point format. Uses one iterative shift-add multiplier, reused for y*y and then e*(1-y^2), to keep area small. Sits between the error-propagation stage and the weight-gradient accumulators.

Parameters:
WIDTH, 32, data width in bits; two's-complement fixed point.
FRAC, 20, number of fractional bits; 1.0 = 1 << FRAC (0x00100000 at the defaults).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
i_start  input  1  request strobe; accepted only when o_ready=1.
i_y  input  WIDTH  tanh activation y, signed Q12.20.
i_err  input  WIDTH  backpropagated error e, signed Q12.20.
o_ready  output  1  high in IDLE; unit can accept i_start.
o_valid  output  1  one-cycle pulse when o_dout and o_grad are updated.
o_dout  output  WIDTH  delta = e*(1-y^2), signed Q12.20; held until the next result.
o_grad  output  WIDTH  local gradient g = 1-y^2, Q12.20, always >= 0; held with o_dout.

Behaviour:
- Reset (async, rst=1): state=IDLE; o_ready=1; o_valid=0; o_dout=0; o_grad=0; internal registers cleared. Reset asserted mid-operation aborts the computation. No result is emitted.
- FSM states:
  - IDLE: if i_start, latch i_y, i_err and the sign of e; go to SQ; o_ready=0 from the next cycle.
  - SQ: multiply |y| by |y| over WIDTH iterations. Each iteration examines one bit of the multiplier, LSB first, and conditionally adds the shifted multiplicand into a 2*WIDTH accumulator.
  - SUB: sq = acc[FRAC+WIDTH-1:FRAC] (truncated). g = ONE - sq if sq < ONE, else g = 0 (clamp when |y| >= 1.0). Go to MUL.
  - MUL: multiply |e| by g over WIDTH iterations using the same datapath.
  - DONE: m = acc[FRAC+WIDTH-1:FRAC]. o_dout = e negative ? -m : m (truncation toward zero, symmetric about 0). o_grad = g. o_valid=1 for this cycle only. Return to IDLE.
- Fixed latency without the optional feature: o_valid rises exactly 2*WIDTH+3 clock edges after the edge that accepted i_start (67 cycles at WIDTH=32). The next i_start can be accepted on the cycle after o_valid.
- i_start while o_ready=0: ignored. No queuing. Latched operands are unaffected.
- No overflow is possible: g <= 1.0, so |delta| <= |e|. The case e = 0x80000000 with g=1.0 returns 0x80000000.
- Input values are sampled only at acceptance. Changes on i_y or i_err during busy states have no effect.

Optional Feature:
TANH_DERIV_EARLY_EN. When defined, SQ and MUL each end early once the remaining unshifted multiplier bits are all zero. If y==0, SQ is skipped entirely (sq=0, g=ONE). Latency becomes variable, minimum 3 cycles. Results are bit-identical to the fixed-latency build. When not defined, latency is always 2*WIDTH+3 and the early-exit logic is absent.

Test Plan:
- y=0x00080000 (0.5), e=0x00200000 (2.0) -> o_grad=0x000C0000, o_dout=0x00180000, o_valid exactly 67 cycles after start (feature off).
- y=0xFFF80000 (-0.5), e=0xFFF00000 (-1.0) -> o_grad=0x000C0000, o_dout=0xFFF40000.
- y=0x00100000 (1.0) and y=0x00180000 (1.5), e=0x00100000 -> o_grad=0, o_dout=0 in both cases (clamp).
- y=0, e=0x7FFFFFFF -> o_grad=0x00100000, o_dout=0x7FFFFFFF. With TANH_DERIV_EARLY_EN, latency is below 67 and the outputs are identical.
- Pulse i_start during busy with different operands -> first result unchanged, second request dropped, o_ready stays 0 until after o_valid.
- Assert rst in the middle of MUL -> o_valid never pulses, o_dout=0, o_ready=1 immediately. A new request afterwards completes correctly.
